// File: rtl/truth_table_sweeper.sv
// Walks a 3-input gate through vectors 000..111, holding each SETTLE_CYCLES, and captures its truth table.
// Done pulses 1+8*SETTLE_CYCLES cycles after the start edge; start is ignored mid-sweep, abort cancels.
module truth_table_sweeper #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [7:0]  EXPECTED      = 8'hB5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       dut_out,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic       busy,
    output logic       done,
    output logic [7:0] signature,
    output logic       match
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        DONE
    } state_t;

    localparam logic [7:0] HOLD_INIT = 8'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [2:0] idx;
    logic [7:0] hold;
    logic [7:0] sig;
    logic [7:0] sig_next;

    // Signature with the current vector's sample merged in, so match can be judged on the final edge.
    always_comb begin
        sig_next      = sig;
        sig_next[idx] = dut_out;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= 3'd0;
            hold  <= 8'd0;
            sig   <= 8'd0;
            match <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start && !abort) begin
                        idx   <= 3'd0;
                        hold  <= HOLD_INIT;
                        sig   <= 8'd0;
                        match <= 1'b0;
                        busy  <= 1'b1;
                        state <= SETTLE;
                    end else begin
                        state <= IDLE;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        state <= IDLE;
                        idx   <= 3'd0;
                        sig   <= 8'd0;
                        match <= 1'b0;
                        busy  <= 1'b0;
                    end else if (hold != 8'd0) begin
                        hold <= hold - 8'd1;
                    end else begin
                        sig <= sig_next;
                        if (idx != 3'd7) begin
                            idx  <= idx + 3'd1;
                            hold <= HOLD_INIT;
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            match <= (sig_next == EXPECTED);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Inputs come straight from the index register so the gate never sees decode glitches.
    assign {in1, in2, in3} = idx;
    assign signature       = sig;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench: elapsed-time reference model compared every cycle plus directed literal checks.
module tb_truth_table_sweeper;

    localparam int S = 2;
    localparam logic [7:0] EXP = 8'hB5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start, abort;
    logic       in1, in2, in3, busy, done, match;
    logic [7:0] signature;
    logic [7:0] tt;
    logic       dut_out;
    assign dut_out = tt[{in1, in2, in3}];

    truth_table_sweeper #(.SETTLE_CYCLES(S), .EXPECTED(EXP)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .dut_out(dut_out),
        .in1(in1), .in2(in2), .in3(in3), .busy(busy), .done(done),
        .signature(signature), .match(match)
    );

    logic       reset1, start1, abort1;
    logic       b_in1, b_in2, b_in3, busy1, done1, match1;
    logic [7:0] signature1;
    logic [7:0] tt1;
    logic       dut_out1;
    assign dut_out1 = tt1[{b_in1, b_in2, b_in3}];

    truth_table_sweeper #(.SETTLE_CYCLES(1), .EXPECTED(EXP)) dut1 (
        .clk(clk), .reset(reset1), .start(start1), .abort(abort1), .dut_out(dut_out1),
        .in1(b_in1), .in2(b_in2), .in3(b_in3), .busy(busy1), .done(done1),
        .signature(signature1), .match(match1)
    );

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: m_t counts cycles since the accepted start (0 = not sweeping).
    int         m_t = 0;
    logic [2:0] m_vec = 3'd0;
    logic [7:0] m_sig = 8'd0;
    logic       m_match = 1'b0;
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;

    always @(posedge clk) begin
        int n;
        logic [7:0] mk;
        if (reset) begin
            m_t = 0; m_vec = 3'd0; m_sig = 8'd0; m_match = 1'b0;
        end else if (m_t >= 1 && m_t <= 8 * S) begin
            if (abort) begin
                m_t = 0; m_vec = 3'd0; m_sig = 8'd0; m_match = 1'b0;
            end else begin
                m_t++;
            end
        end else if (start && !abort) begin
            m_t = 1;
        end else begin
            m_t = 0;
        end
        if (m_t >= 1) begin
            n       = (m_t - 1) / S;
            mk      = 8'((1 << n) - 1);
            m_vec   = (n > 7) ? 3'd7 : 3'(n);
            m_sig   = (n >= 8) ? tt : (tt & mk);
            m_match = (n >= 8) && (tt == EXP);
        end
        m_busy = (m_t >= 1) && (m_t <= 8 * S);
        m_done = (m_t == 8 * S + 1);
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_inputs", {in1, in2, in3}, m_vec);
            chk("model_busy", busy, m_busy);
            chk("model_done", done, m_done);
            chk("model_signature", signature, m_sig);
            chk("model_match", match, m_match);
        end
    end

    task automatic run_sweep(input logic [7:0] gate, input int restart_at,
                             output int lat, output int ndone,
                             output logic [7:0] sig_at_done, output logic match_at_done);
        tt = gate;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1; ndone = 0; sig_at_done = 8'hxx; match_at_done = 1'bx;
        for (int c = 1; c <= 40; c++) begin
            if (done === 1'b1) begin
                ndone++;
                if (lat < 0) begin
                    lat = c;
                    sig_at_done = signature;
                    match_at_done = match;
                end
            end
            start = (c == restart_at);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        int lat, nd, d1, d2, cnt;
        logic [7:0] sg;
        logic mt;
        bit found;

        reset = 1'b1; start = 1'b0; abort = 1'b0; tt = EXP;
        reset1 = 1'b1; start1 = 1'b0; abort1 = 1'b0; tt1 = EXP;
        @(negedge clk);
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0; reset1 = 1'b0;
        @(negedge clk);

        chk("reset_inputs", {in1, in2, in3}, 3'b000);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_signature", signature, 8'h00);
        chk("reset_match", match, 1'b0);

        run_sweep(8'hB5, 0, lat, nd, sg, mt);
        chk("nominal_latency", lat, 17);
        chk("nominal_done_count", nd, 1);
        chk("nominal_signature", sg, 8'hB5);
        chk("nominal_match", mt, 1'b1);
        chk("nominal_inputs_after", {in1, in2, in3}, 3'b111);

        run_sweep(8'h4A, 0, lat, nd, sg, mt);
        chk("fault_latency", lat, 17);
        chk("fault_signature", sg, 8'h4A);
        chk("fault_match", mt, 1'b0);

        run_sweep(8'hB5, 6, lat, nd, sg, mt);
        chk("restart_ignored_latency", lat, 17);
        chk("restart_ignored_done_count", nd, 1);
        chk("restart_ignored_signature", sg, 8'hB5);

        // Abort while vector 3 is on the gate.
        tt = 8'hB5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            if ({in1, in2, in3} == 3'd3) found = 1'b1;
            else @(negedge clk);
        end
        chk("abort_reached_idx3", found, 1'b1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_inputs", {in1, in2, in3}, 3'b000);
        chk("abort_signature", signature, 8'h00);
        cnt = 0;
        for (int c = 0; c < 30; c++) begin
            if (done === 1'b1) cnt++;
            @(negedge clk);
        end
        chk("abort_no_done", cnt, 0);

        // Reset during cycle 9 of a sweep.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midreset_inputs", {in1, in2, in3}, 3'b000);
        chk("midreset_busy", busy, 1'b0);
        chk("midreset_signature", signature, 8'h00);
        chk("midreset_match", match, 1'b0);
        cnt = 0;
        for (int c = 0; c < 30; c++) begin
            if (done === 1'b1) cnt++;
            @(negedge clk);
        end
        chk("midreset_no_done", cnt, 0);

        // SETTLE_CYCLES=1 with start held high: back-to-back sweeps.
        start1 = 1'b1;
        @(negedge clk);
        d1 = -1; d2 = -1;
        for (int c = 1; c <= 20; c++) begin
            if (done1 === 1'b1) begin
                if (d1 < 0) begin
                    d1 = c;
                    chk("b2b_signature", signature1, 8'hB5);
                    chk("b2b_match", match1, 1'b1);
                end else if (d2 < 0) begin
                    d2 = c;
                end
            end
            @(negedge clk);
        end
        start1 = 1'b0;
        chk("b2b_first_done", d1, 9);
        chk("b2b_second_done", d2, 18);

        // Randomized traffic; the gate table only changes while the model is idle.
        for (int i = 0; i < 600; i++) begin
            if (m_t == 0 && $urandom_range(0, 3) == 0) tt = 8'($urandom);
            start = ($urandom_range(0, 5) == 0);
            abort = ($urandom_range(0, 40) == 0);
            reset = ($urandom_range(0, 150) == 0);
            @(negedge clk);
        end
        start = 1'b0; abort = 1'b0; reset = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Stimulus-and-capture stage that wraps a 3-input combinational logic gate (the Wolfram-style 3-input truth-table blocks).
- Upstream: drives in1/in2/in3 through all 8 input combinations in ascending order.
- Downstream: samples the gate's single output after a settle window and assembles an 8-bit truth-table signature.
- Compares the signature against an expected code (default 0xB5) and reports pass/fail.

Parameters:
- SETTLE_CYCLES, 2, cycles each input vector is held before the gate output is sampled; legal range 1..255.
- EXPECTED, 8'hB5, expected signature; bit i is the required gate output for {in1,in2,in3} = i.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a sweep; accepted only in IDLE.
- abort  input  1  cancels a sweep in progress.
- dut_out  input  1  output of the gate under sweep.
- in1  output  1  gate input, MSB of vector index.
- in2  output  1  gate input, middle bit of vector index.
- in3  output  1  gate input, LSB of vector index.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when a sweep completes.
- signature  output  8  captured truth table; bit i = dut_out sampled for vector i.
- match  output  1  signature == EXPECTED; valid from the done cycle onward.

Behaviour:
- Reset is synchronous, active-high, on clk. While reset is high: state=IDLE; in1/in2/in3=0, busy=0, done=0, signature=8'h00, match=0. Overrides start/abort.
- Registers:
  - idx, 3 bits, the vector index.
  - hold, 8-bit down-counter.
  - sig, 8 bits.
- {in1,in2,in3} = idx, driven from a register (glitch-free).
- States: IDLE, SETTLE, DONE.
- IDLE:
  - busy=0.
  - On start=1 at edge k: idx<=0, hold<=SETTLE_CYCLES-1, sig<=0, match<=0, state<=SETTLE.
  - The vector 000 is therefore present from cycle k+1.
- SETTLE:
  - busy=1.
  - If hold!=0: hold decrements.
  - If hold==0: sig[idx]<=dut_out.
    - If idx!=7: idx increments, hold reloads SETTLE_CYCLES-1.
    - If idx==7: state<=DONE.
  - Each vector is held exactly SETTLE_CYCLES cycles. dut_out is sampled on the edge that ends the vector's last hold cycle.
- DONE:
  - One cycle: done=1, busy=0; signature and match present the final values.
  - Next edge returns to IDLE.
  - A start asserted during DONE is accepted as if in IDLE (back-to-back sweep).
- Latency: start at edge k → done high during cycle k+1+8*SETTLE_CYCLES. Default: 17 cycles after the start edge.
- signature/match hold their last values through IDLE until the next accepted start clears them. Intermediate partial sig is visible on signature during the sweep; match is 0 during the sweep.
- in1..in3 remain at 111 after completion until the next start or reset.
- start while in SETTLE: ignored, no restart.
- abort in SETTLE:
  - Next state IDLE; idx<=0 (inputs return to 000); sig<=0; match=0.
  - done is never pulsed.
  - abort has priority over a sample/advance on the same edge.
- abort in IDLE/DONE: no effect. start and abort together in IDLE: abort wins, start dropped.
- Reset mid-sweep: identical to the reset state above; no done pulse.

Test Plan:
- Reset values: hold reset 3 cycles, release → in1..3=000, busy=0, done=0, signature=0x00, match=0.
- Nominal: bench models the 0xB5 gate, SETTLE_CYCLES=2, start at edge 0 → each vector held 2 cycles (000,001,…,111), done pulse in cycle 17, signature=0xB5, match=1.
- Fault detection: model with inverted output → signature=0x4A, match=0, done still in cycle 17.
- Start ignored while busy: second start at cycle 6 → no restart, done still in cycle 17, signature=0xB5.
- Abort mid-sweep: abort while idx=3 → next cycle busy=0, inputs=000, signature=0x00, no done pulse.
- Reset mid-sweep and back-to-back sweeps:
  - Reset at cycle 9 → outputs per the reset state, no done.
  - Separately, SETTLE_CYCLES=1 with start held high → done in cycle 9, a new sweep begins immediately, and a second done arrives in cycle 18.
